// File: rtl/tg_run_ctrl.sv
// tg_run_ctrl: sequences one traffic-generator run (config load, warmup,
// measure, drain, stats read) and handles the host command handshake.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   cmd_valid/cmd_ready/cmd/cmd_arg  host command handshake, accepted only in IDLE
//   wdata*/tg_config_out*            config word stream, forwarded to the TG chain
//   rdata*/tg_stats_*                stats word stream, shifted out of the TG chain
//   tg_enable/tg_measure/            phase controls for the TGs
//   tg_stop_injection, sim_time
//   tg_is_quiescent, tg_error        reduced chain status
//   busy/done/status_*               run status towards the host
module tg_run_ctrl #(
  parameter int CHAIN_LEN     = 4,
  parameter int STATS_LEN     = 8,
  parameter int TS_WIDTH      = 10,
  parameter int QUIESCE_HOLD  = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd,
  input  logic [15:0]         cmd_arg,
  input  logic [15:0]         wdata,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  output logic [15:0]         rdata,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [15:0]         tg_config_out,
  output logic                tg_config_out_valid,
  output logic                tg_stats_shift,
  output logic [15:0]         tg_stats_in,
  input  logic [15:0]         tg_stats_out,
  output logic                tg_enable,
  output logic                tg_measure,
  output logic                tg_stop_injection,
  output logic [TS_WIDTH-1:0] sim_time,
  input  logic                tg_is_quiescent,
  input  logic                tg_error,
  output logic                busy,
  output logic                done,
  output logic                status_error,
  output logic                status_timeout
);

  // Word counter must hold the larger of the two chain lengths without wrapping.
  localparam int MAXLEN = (CHAIN_LEN > STATS_LEN) ? CHAIN_LEN : STATS_LEN;
  localparam int WW     = $clog2(MAXLEN + 1);
  localparam int QW     = $clog2(QUIESCE_HOLD + 1);

  localparam logic [WW-1:0] CHAIN_LEN_W = WW'(CHAIN_LEN);
  localparam logic [WW-1:0] STATS_LEN_W = WW'(STATS_LEN);
  localparam logic [QW-1:0] QHOLD_W     = QW'(QUIESCE_HOLD);
  localparam logic [15:0]   DTIMEOUT_W  = 16'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_MEASURE,
    S_DRAIN,
    S_READ
  } state_t;

  state_t                state_q;
  logic [15:0]           warmup_cnt_q;
  logic [15:0]           measure_cnt_q;
  logic [15:0]           phase_cnt_q;
  logic [15:0]           drain_cnt_q;
  logic [QW-1:0]         quiet_cnt_q;
  logic [WW-1:0]         word_cnt_q;
  logic [TS_WIDTH-1:0]   sim_time_q;
  logic [15:0]           cfg_dat_q;
  logic                  cfg_vld_q;
  logic                  done_q;
  logic                  err_q;
  logic                  tmo_q;

  logic [QW-1:0]         quiet_cnt_d;
  logic [15:0]           drain_cnt_d;
  logic [WW-1:0]         word_cnt_d;
  logic                  quiet_hit;
  logic                  timeout_hit;
  logic                  cfg_acc;
  logic                  stats_hs;

  // Phase-control outputs are plain decodes of the state register.
  assign cmd_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign wdata_ready       = (state_q == S_LOAD);
  assign rdata_valid       = (state_q == S_READ);
  assign rdata             = tg_stats_out;
  assign tg_stats_in       = 16'h0000;
  assign tg_stats_shift    = stats_hs;
  assign tg_enable         = (state_q == S_WARMUP) || (state_q == S_MEASURE) || (state_q == S_DRAIN);
  assign tg_measure        = (state_q == S_MEASURE);
  assign tg_stop_injection = (state_q == S_DRAIN);
  assign tg_config_out     = cfg_dat_q;
  assign tg_config_out_valid = cfg_vld_q;
  assign sim_time          = sim_time_q;
  assign done              = done_q;
  assign status_error      = err_q;
  assign status_timeout    = tmo_q;

  assign cfg_acc  = wdata_valid && (state_q == S_LOAD);
  assign stats_hs = rdata_valid && rdata_ready;

  always_comb begin
    quiet_cnt_d = tg_is_quiescent ? (quiet_cnt_q + 1'b1) : '0;
    drain_cnt_d = drain_cnt_q + 16'd1;
    word_cnt_d  = word_cnt_q + 1'b1;
    // Quiescence is tested before the timeout so that reaching both on
    // the same cycle counts as a clean drain.
    quiet_hit   = (quiet_cnt_d == QHOLD_W);
    timeout_hit = (drain_cnt_d == DTIMEOUT_W);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      warmup_cnt_q  <= '0;
      measure_cnt_q <= '0;
      phase_cnt_q   <= '0;
      drain_cnt_q   <= '0;
      quiet_cnt_q   <= '0;
      word_cnt_q    <= '0;
      sim_time_q    <= '0;
      cfg_dat_q     <= '0;
      cfg_vld_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_vld_q <= 1'b0;
      if (tg_enable) begin
        sim_time_q <= sim_time_q + 1'b1;
        if (tg_error) err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              3'd0: warmup_cnt_q  <= cmd_arg;
              3'd1: measure_cnt_q <= cmd_arg;
              3'd2: begin
                word_cnt_q <= '0;
                state_q    <= S_LOAD;
              end
              3'd3: begin
                sim_time_q  <= '0;
                err_q       <= 1'b0;
                tmo_q       <= 1'b0;
                // Phase counter counts 1..N inside a phase.
                phase_cnt_q <= 16'd1;
                drain_cnt_q <= '0;
                quiet_cnt_q <= '0;
                if (warmup_cnt_q != 16'd0)       state_q <= S_WARMUP;
                else if (measure_cnt_q != 16'd0) state_q <= S_MEASURE;
                else                             state_q <= S_DRAIN;
              end
              3'd4: begin
                word_cnt_q <= '0;
                state_q    <= S_READ;
              end
              default: ;
            endcase
          end
        end

        S_LOAD: begin
          if (cfg_acc) begin
            cfg_dat_q  <= wdata;
            cfg_vld_q  <= 1'b1;
            word_cnt_q <= word_cnt_d;
            // done is registered alongside the last config_out_valid.
            if (word_cnt_d == CHAIN_LEN_W) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        S_WARMUP: begin
          if (phase_cnt_q == warmup_cnt_q) begin
            phase_cnt_q <= 16'd1;
            if (measure_cnt_q != 16'd0) state_q <= S_MEASURE;
            else                        state_q <= S_DRAIN;
          end else begin
            phase_cnt_q <= phase_cnt_q + 16'd1;
          end
        end

        S_MEASURE: begin
          if (phase_cnt_q == measure_cnt_q) begin
            state_q <= S_DRAIN;
          end else begin
            phase_cnt_q <= phase_cnt_q + 16'd1;
          end
        end

        S_DRAIN: begin
          quiet_cnt_q <= quiet_cnt_d;
          drain_cnt_q <= drain_cnt_d;
          if (quiet_hit) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
          end
        end

        S_READ: begin
          if (stats_hs) begin
            word_cnt_q <= word_cnt_d;
            if (word_cnt_d == STATS_LEN_W) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tg_run_ctrl.md
TG_RUN_CTRL -- requirements
Module: tg_run_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 4: number of 16-bit words in the TG configuration chain.
REQ-002 Parameter STATS_LEN, default 8: number of 16-bit words in the TG stats chain.
REQ-003 Parameter TS_WIDTH, default 10: sim_time width.
REQ-004 Parameter QUIESCE_HOLD, default 4: consecutive quiescent cycles that end a drain.
REQ-005 Parameter DRAIN_TIMEOUT, default 1024: maximum drain cycles (16-bit counter).
REQ-006 Reset is reset, synchronous, active-high; clock is clock.
REQ-007 clock  in  1  system clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 cmd_valid/cmd_ready  in/out  1/1  host command handshake.
REQ-010 cmd  in  3  0=SET_WARMUP, 1=SET_MEASURE, 2=LOAD_CONFIG, 3=RUN, 4=READ_STATS; 5-7 are ignored.
REQ-011 cmd_arg  in  16  cycle count for SET_WARMUP/SET_MEASURE.
REQ-012 wdata/wdata_valid/wdata_ready  in/in/out  16/1/1  config word stream.
REQ-013 rdata/rdata_valid/rdata_ready  out/out/in  16/1/1  stats word stream.
REQ-014 tg_config_out/tg_config_out_valid  out  16/1  TG config chain input.
REQ-015 tg_stats_shift  out  1; tg_stats_in  out  16 (constant 0); tg_stats_out  in  16  chain tail.
REQ-016 tg_enable, tg_measure, tg_stop_injection  out  1 each.
REQ-017 sim_time  out  TS_WIDTH.
REQ-018 tg_is_quiescent, tg_error  in  1 each  AND-/OR-reduced chain status.
REQ-019 busy, done (1-cycle pulse), status_error, status_timeout  out  1 each.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, WARMUP, MEASURE, DRAIN and READ; cmd_ready=1 only in IDLE, busy=1 when not in IDLE.
REQ-021 In IDLE, cmd_valid&cmd_ready SHALL execute as follows: SET_WARMUP/SET_MEASURE load cmd_arg into warmup_cnt/measure_cnt and stay IDLE; LOAD_CONFIG goes to LOAD; RUN clears sim_time, status_error and status_timeout; READ_STATS goes to READ; codes 5-7 are consumed with no effect.
REQ-022 RUN SHALL enter WARMUP if warmup_cnt!=0, else MEASURE if measure_cnt!=0, else DRAIN.
REQ-023 LOAD: wdata_ready=1; each accepted word SHALL appear on tg_config_out with tg_config_out_valid=1 for exactly one cycle, one cycle after acceptance; after CHAIN_LEN accepts, return to IDLE and pulse done on the cycle of the last config_out_valid.
REQ-024 WARMUP SHALL last exactly warmup_cnt cycles and MEASURE exactly measure_cnt cycles; zero-length phases are skipped per REQ-022.
REQ-025 tg_enable=1 in WARMUP, MEASURE and DRAIN; tg_measure=1 only in MEASURE; tg_stop_injection=1 only in DRAIN.
REQ-026 sim_time SHALL increment by 1 every cycle tg_enable=1, wrapping modulo 2^TS_WIDTH, and hold otherwise.
REQ-027 DRAIN SHALL count consecutive cycles with tg_is_quiescent=1; a 0 restarts the count; at QUIESCE_HOLD the FSM goes to IDLE and pulses done.
REQ-028 If DRAIN reaches DRAIN_TIMEOUT cycles first, the FSM SHALL set status_timeout, go to IDLE and pulse done; quiescence on the same cycle takes priority (no timeout).
REQ-029 tg_error=1 in any cycle with tg_enable=1 SHALL set sticky status_error; the run continues.
REQ-030 READ: rdata=tg_stats_out (combinational), rdata_valid=1; tg_stats_shift=rdata_valid&rdata_ready; after STATS_LEN handshakes, return to IDLE and pulse done.
REQ-031 rdata_ready=0 or wdata_valid=0 SHALL stall READ/LOAD indefinitely with no shift and no config output.
REQ-032 Word counters SHALL be wide enough for CHAIN_LEN and STATS_LEN with no wrap.

Reset
REQ-033 Reset at any time, including mid-phase, SHALL force IDLE on the next edge. All outputs become 0, except cmd_ready=1. sim_time, warmup_cnt, measure_cnt, all internal counters and both status bits become 0.

Verification
REQ-034 LOAD_CONFIG, 4 words 0x1111..0x4444 with gaps -> 4 single-cycle config_out_valid pulses with the same values in order; done pulses once; wdata_ready returns to 0.
REQ-035 warmup=3, measure=5, RUN, tg_is_quiescent held 1 -> tg_enable high for 3+5+4=12 cycles; tg_measure high for cycles 4-8; sim_time=12 at end; done pulses.
REQ-036 warmup=0, measure=0, RUN, quiescent toggling 1,1,0,1,1,1,1 -> DRAIN ends after the 7th cycle; status_timeout=0.
REQ-037 DRAIN_TIMEOUT=16, tg_is_quiescent=0 -> status_timeout=1 after 16 drain cycles; a later RUN clears it.
REQ-038 READ_STATS with rdata_ready toggling every cycle -> exactly 8 tg_stats_shift pulses, each coinciding with a handshake.
REQ-039 Reset asserted mid-MEASURE with tg_error pulsed earlier -> the next cycle shows IDLE, tg_enable=0, sim_time=0, status_error=0 and cmd_ready=1.
